// File: rtl/dadda_pkg.sv
// Shared types and helpers for the Dadda multiplier datapath.
// Consumed by the product accumulator and its neighbours.
package dadda_pkg;

   localparam int PROD_W_DEF = 17;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Increment that sticks at vmax instead of wrapping.
   function automatic logic [31:0] sat_inc(
      input logic [31:0] v,
      input logic [31:0] vmax
   );
      return (v >= vmax) ? vmax : v + 32'd1;
   endfunction

endpackage

// File: rtl/dadda_mac_accum.sv
// Frame accumulator for the Dadda multiplier product stream.
// Sums beats per frame and presents one held result per frame.
module dadda_mac_accum
   import dadda_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W  = 24,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_acc,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf
);

   localparam logic [31:0] CNT_MAX =
      32'((64'd1 << CNT_W) - 64'd1);

   state_t           state;
   state_t           state_nx;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] count;
   logic             ovf;

   logic             take;
   logic [ACC_W:0]   sum;
   logic             carry;
   logic [CNT_W-1:0] count_inc;

   assign take = in_valid && in_ready;

   // One ACC_W+1 bit add; the top bit is the carry out.
   assign sum = {1'b0, acc}
              + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
   assign carry = sum[ACC_W];

   assign count_inc =
      CNT_W'(sat_inc(32'(count), CNT_MAX));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE, ACCUM: begin
            if (take) begin
               state_nx = in_last ? HOLD : ACCUM;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Handshake outputs decode the registered state only.
   always_comb begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
      unique case (state)
         HOLD: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
         end
         default: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         out_acc   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else if (take) begin
         if (in_last) begin
            out_acc   <= sum[ACC_W-1:0];
            out_count <= count_inc;
            out_ovf   <= ovf | carry;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
         end else begin
            acc   <= sum[ACC_W-1:0];
            count <= count_inc;
            ovf   <= ovf | carry;
         end
      end
   end

endmodule

// File: tb/tb_dadda_mac_accum.sv
// Randomized bench for dadda_mac_accum, two widths in lockstep.
// Expected sums come from plain integer arithmetic on the frame.
module tb_dadda_mac_accum;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b0;
   logic [16:0] in_prod = '0;

   logic        in_ready_a, out_valid_a, out_ovf_a;
   logic [23:0] out_acc_a;
   logic [7:0]  out_count_a;
   logic        in_ready_b, out_valid_b, out_ovf_b;
   logic [16:0] out_acc_b;
   logic [7:0]  out_count_b;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   dadda_mac_accum #(.PROD_W(17), .ACC_W(24), .CNT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready_a),
      .in_prod(in_prod), .in_last(in_last),
      .out_valid(out_valid_a), .out_ready(out_ready),
      .out_acc(out_acc_a), .out_count(out_count_a),
      .out_ovf(out_ovf_a)
   );

   dadda_mac_accum #(.PROD_W(17), .ACC_W(17), .CNT_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready_b),
      .in_prod(in_prod), .in_last(in_last),
      .out_valid(out_valid_b), .out_ready(out_ready),
      .out_acc(out_acc_b), .out_count(out_count_b),
      .out_ovf(out_ovf_b)
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d",
                  tag, got, exp);
      end
   endtask

   // Expected frame result from the whole-frame sum.
   logic [63:0] e_acc_a, e_acc_b, e_cnt;
   logic        e_ovf_a, e_ovf_b;

   task automatic set_expect(input longint s, input int n);
      e_acc_a = 64'(s % (64'd1 << 24));
      e_acc_b = 64'(s % (64'd1 << 17));
      e_ovf_a = (s >= (64'd1 << 24));
      e_ovf_b = (s >= (64'd1 << 17));
      e_cnt   = (n > 255) ? 64'd255 : 64'(n);
   endtask

   task automatic chk_outs(input string tag);
      chk({tag, "_acc_a"}, 64'(out_acc_a), e_acc_a);
      chk({tag, "_acc_b"}, 64'(out_acc_b), e_acc_b);
      chk({tag, "_cnt_a"}, 64'(out_count_a), e_cnt);
      chk({tag, "_cnt_b"}, 64'(out_count_b), e_cnt);
      chk({tag, "_ovf_a"}, 64'(out_ovf_a), 64'(e_ovf_a));
      chk({tag, "_ovf_b"}, 64'(out_ovf_b), 64'(e_ovf_b));
   endtask

   // Called and returns at a falling edge; beat accepted in between.
   task automatic beat(input logic [16:0] p, input logic last);
      int g = 0;
      while ($urandom_range(0, 3) == 0) begin
         in_valid = 1'b0;
         in_prod  = 17'($urandom);
         in_last  = 1'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_prod  = p;
      in_last  = last;
      while (!in_ready_a && g < 64) begin
         @(negedge clk);
         g++;
      end
      if (!in_ready_a) chk("ready_timeout", 64'd0, 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic run_frame(input int unsigned p[$],
                            input int hold);
      longint s = 0;
      int n = p.size();
      foreach (p[i]) s += longint'(p[i]);
      set_expect(s, n);
      for (int i = 0; i < n; i++) begin
         beat(17'(p[i]), (i == n - 1));
      end
      chk("lat_valid_a", 64'(out_valid_a), 64'd1);
      chk("lat_valid_b", 64'(out_valid_b), 64'd1);
      chk_outs("res");
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("bp_ready", 64'(in_ready_a), 64'd0);
         chk("bp_valid", 64'(out_valid_a), 64'd1);
         chk_outs("bp");
      end
      out_ready = 1'b1;
      chk("bubble_ready", 64'(in_ready_a), 64'd0);
      @(negedge clk);
      out_ready = 1'b0;
      chk("drop_valid_a", 64'(out_valid_a), 64'd0);
      chk("drop_valid_b", 64'(out_valid_b), 64'd0);
      chk("idle_ready", 64'(in_ready_b), 64'd1);
      chk_outs("held");
   endtask

   int unsigned q[$];

   initial begin
      #100000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      set_expect(0, 0);
      chk("rst_valid", 64'(out_valid_a), 64'd0);
      chk("rst_ready", 64'(in_ready_a), 64'd1);
      chk_outs("rst");
      rst_n = 1'b1;
      @(negedge clk);

      q = '{1242, 270, 460};
      run_frame(q, 5);
      q = '{3969};
      run_frame(q, 0);

      q.delete();
      repeat (34) q.push_back(3969);
      run_frame(q, 1);
      q = '{5};
      run_frame(q, 0);

      q.delete();
      repeat (300) q.push_back(1);
      run_frame(q, 0);

      // Abandon a partial frame with an asynchronous reset.
      beat(17'd100, 1'b0);
      beat(17'd100, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      set_expect(0, 0);
      chk("arst_valid", 64'(out_valid_a), 64'd0);
      chk("arst_ready", 64'(in_ready_a), 64'd1);
      chk_outs("arst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("no_stale", 64'(out_valid_a), 64'd0);
      end
      q = '{7};
      run_frame(q, 0);

      for (int f = 0; f < 25; f++) begin
         int len = $urandom_range(1, 9);
         q.delete();
         for (int i = 0; i < len; i++) begin
            if (f % 2 == 0) q.push_back($urandom_range(0, 3969));
            else q.push_back($urandom_range(0, 131071));
         end
         run_frame(q, $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nerr);
      $finish;
   end

endmodule
